// File: rtl/shift_register_seq.sv
// -----------------------------------------------------------------------------
// shift_register_seq
//
// Purpose:
//   Drives one external shift register. A parallel word is accepted on a
//   valid/ready handshake and parallel-loaded into the register. The sequencer
//   then issues exactly WIDTH shift pulses, one every DIV clocks. After the
//   last pulse it captures the register contents and presents them with a
//   one-cycle receive strobe.
//
// Parameters:
//   WIDTH  word length. It must match the controlled shift register (>= 2).
//   DIV    clocks per bit period (>= 1). DIV = 1 shifts on every cycle.
//
// Ports:
//   clk              in   1      system clock; all state changes on the rising edge
//   n_reset          in   1      asynchronous, active-low reset
//   s_valid          in   1      input word valid
//   s_ready          out  1      the sequencer can accept a word
//   s_data           in   WIDTH  word to serialise
//   abort            in   1      synchronous cancel of the word in flight
//   sr_load          out  1      to shift_register.load
//   sr_shift         out  1      to shift_register.shift
//   sr_load_data     out  WIDTH  to shift_register.load_data
//   sr_current_data  in   WIDTH  from shift_register.current_data
//   busy             out  1      high in every state except IDLE
//   done             out  1      one-cycle pulse when a word completes
//   rx_valid         out  1      one-cycle pulse; rx_data has just been updated
//   rx_data          out  WIDTH  captured register contents
//
// Configuration macro:
//   SHIFT_SEQ_BACK_TO_BACK_EN
//     When defined, s_ready is also high in DONE.
//     A word accepted in DONE goes straight to LOAD. The completion strobe
//     and the rx capture still happen for the finishing word.
// -----------------------------------------------------------------------------
module shift_register_seq #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             abort,
  output logic             sr_load,
  output logic             sr_shift,
  output logic [WIDTH-1:0] sr_load_data,
  input  logic [WIDTH-1:0] sr_current_data,
  output logic             busy,
  output logic             done,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data
);

  // A DIV of 1 still needs a one-bit counter. That counter simply stays at 0.
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] load_data_reg, load_data_next;
  logic [WIDTH-1:0] rx_data_reg, rx_data_next;
  logic             rx_valid_reg, rx_valid_next;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg     <= IDLE;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      load_data_reg <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      load_data_reg <= load_data_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    load_data_next = load_data_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    s_ready        = 1'b0;
    sr_load        = 1'b0;
    sr_shift       = 1'b0;
    done           = 1'b0;

    case (state_reg)
      IDLE: begin
        // abort has no effect here, so an accept still proceeds.
        s_ready = 1'b1;
        if (s_valid) begin
          state_next     = LOAD;
          load_data_next = s_data;
        end
      end

      LOAD: begin
        sr_load      = 1'b1;
        div_cnt_next = '0;
        bit_cnt_next = '0;
        state_next   = abort ? IDLE : SHIFT;
      end

      SHIFT: begin
        sr_shift = (div_cnt_reg == DIV_LAST);
        if (sr_shift) begin
          div_cnt_next = '0;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = DONE;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
        if (abort) begin
          state_next = IDLE;
        end
      end

      DONE: begin
        state_next = IDLE;
        // An abort in DONE suppresses the completion strobe and the capture.
        // rx_data keeps its old value.
        if (!abort) begin
          done          = 1'b1;
          rx_data_next  = sr_current_data;
          rx_valid_next = 1'b1;
`ifdef SHIFT_SEQ_BACK_TO_BACK_EN
          s_ready = 1'b1;
          if (s_valid) begin
            state_next     = LOAD;
            load_data_next = s_data;
          end
`endif
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy         = (state_reg != IDLE);
  assign sr_load_data = load_data_reg;
  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;

endmodule

// File: tb/tb_shift_register_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_register_seq
//
// Directed bench for shift_register_seq.
//   - u_dut uses WIDTH = 8 and DIV = 4.
//   - u_dut1 uses WIDTH = 8 and DIV = 1.
// Each DUT drives a small behavioural shift register (left shift).
//   - u_dut's register shifts in either its own MSB (loopback) or a constant 1.
//   - u_dut1's register is always in loopback.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_register_seq;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       abort = 1'b0;

  // DIV = 4 instance
  logic       s_valid = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_ready, sr_load, sr_shift, busy, done, rx_valid;
  logic [7:0] sr_load_data, sr_cur, rx_data;

  // DIV = 1 instance
  logic       s_valid1 = 1'b0;
  logic [7:0] s_data1  = 8'h00;
  logic       s_ready1, sr_load1, sr_shift1, busy1, done1, rx_valid1;
  logic [7:0] sr_load_data1, sr_cur1, rx_data1;

  logic       loop_mode = 1'b1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  shift_register_seq #(.WIDTH(8), .DIV(4)) u_dut (
    .clk(clk), .n_reset(n_reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .abort(abort), .sr_load(sr_load), .sr_shift(sr_shift),
    .sr_load_data(sr_load_data), .sr_current_data(sr_cur), .busy(busy),
    .done(done), .rx_valid(rx_valid), .rx_data(rx_data)
  );

  shift_register_seq #(.WIDTH(8), .DIV(1)) u_dut1 (
    .clk(clk), .n_reset(n_reset), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data1), .abort(abort), .sr_load(sr_load1), .sr_shift(sr_shift1),
    .sr_load_data(sr_load_data1), .sr_current_data(sr_cur1), .busy(busy1),
    .done(done1), .rx_valid(rx_valid1), .rx_data(rx_data1)
  );

  // Behavioural shift registers
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset)      sr_cur <= 8'h00;
    else if (sr_load)  sr_cur <= sr_load_data;
    else if (sr_shift) sr_cur <= {sr_cur[6:0], (loop_mode ? sr_cur[7] : 1'b1)};
  end

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset)       sr_cur1 <= 8'h00;
    else if (sr_load1)  sr_cur1 <= sr_load_data1;
    else if (sr_shift1) sr_cur1 <= {sr_cur1[6:0], sr_cur1[7]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on u_dut and checks the full timeline.
  // Edge n counts rising edges after the accept edge.
  task automatic run_word(input logic [7:0] d, input logic [7:0] exp_rx, input string tag);
    int pulses = 0;
    int bad = 0;
    int done_at = -1;
    int rxv_at = -1;
    logic [7:0] rx_cap = 8'h00;
    s_valid = 1'b1;
    s_data = d;
    tick();
    s_valid = 1'b0;
    s_data = ~d;  // must be ignored from here on
    checks++;
    if (sr_load !== 1'b1) begin
      errors++;
      $display("FAIL %s_load_after_accept: got %b want 1", tag, sr_load);
    end
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (sr_shift === 1'b1) begin
        pulses++;
        if (n != 4 * pulses) bad++;
      end
      if (sr_shift === 1'b1 && sr_load === 1'b1) bad++;
      if (done === 1'b1 && done_at < 0) done_at = n;
      if (rx_valid === 1'b1 && rxv_at < 0) begin
        rxv_at = n;
        rx_cap = rx_data;
      end
    end
    checks++;
    if (pulses != 8) begin
      errors++;
      $display("FAIL %s_pulse_count: got %0d want 8", tag, pulses);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_pulse_spacing: got %0d bad pulses want 0", tag, bad);
    end
    checks++;
    if (done_at != 33) begin
      errors++;
      $display("FAIL %s_done_latency: got %0d want 33", tag, done_at);
    end
    checks++;
    if (rxv_at != 34) begin
      errors++;
      $display("FAIL %s_rx_valid_latency: got %0d want 34", tag, rxv_at);
    end
    checks++;
    if (rx_cap !== exp_rx) begin
      errors++;
      $display("FAIL %s_rx_data: got %h want %h", tag, rx_cap, exp_rx);
    end
    $display("word %s: sent %h rx %h done@%0d rx_valid@%0d pulses %0d",
             tag, d, rx_cap, done_at, rxv_at, pulses);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({s_ready, busy, sr_load, sr_shift, done, rx_valid} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {s_ready, busy, sr_load, sr_shift, done, rx_valid});
    end
    checks++;
    if (rx_data !== 8'h00 || sr_load_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got rx %h load %h want 00 00", rx_data, sr_load_data);
    end
    tick();
    tick();
    n_reset = 1'b1;
    tick();
    $display("reset: initial state checked");
  endtask

  task automatic test_reset_mid();
    s_valid = 1'b1;
    s_data = 8'h96;
    tick();
    s_valid = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy_before: got %b want 1", busy);
    end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if ({s_ready, busy, sr_load, sr_shift, done, rx_valid} !== 6'b100000) begin
      errors++;
      $display("FAIL midreset_ctrl: got %b want 100000",
               {s_ready, busy, sr_load, sr_shift, done, rx_valid});
    end
    checks++;
    if (rx_data !== 8'h00 || sr_load_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_data: got rx %h load %h want 00 00", rx_data, sr_load_data);
    end
    tick();
    n_reset = 1'b1;
    tick();
    $display("reset mid-SHIFT: outputs returned to reset values");
  endtask

  task automatic test_div1();
    int pulses = 0;
    int bad = 0;
    int done_at = -1;
    logic [7:0] rx_cap = 8'h00;
    s_valid1 = 1'b1;
    s_data1 = 8'h3C;
    tick();
    s_valid1 = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (sr_shift1 === 1'b1) begin
        pulses++;
        if (n != pulses) bad++;
      end
      if (done1 === 1'b1 && done_at < 0) done_at = n;
      if (rx_valid1 === 1'b1) rx_cap = rx_data1;
    end
    checks++;
    if (pulses != 8 || bad != 0) begin
      errors++;
      $display("FAIL div1_pulses: got %0d (bad %0d) want 8 consecutive", pulses, bad);
    end
    checks++;
    if (done_at != 9) begin
      errors++;
      $display("FAIL div1_done_latency: got %0d want 9", done_at);
    end
    checks++;
    if (rx_cap !== 8'h3C) begin
      errors++;
      $display("FAIL div1_rx_data: got %h want 3c", rx_cap);
    end
    $display("word div1: sent 3c rx %h done@%0d pulses %0d", rx_cap, done_at, pulses);
  endtask

  // Precondition: rx_data holds FF from the fill test.
  task automatic test_abort();
    int bad = 0;
    loop_mode = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h5A;
    tick();
    s_valid = 1'b0;
    for (int n = 1; n <= 10; n++) tick();  // cycle 10: inside the 3rd bit period
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_to_idle: got busy %b ready %b want 0 1", busy, s_ready);
    end
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done === 1'b1 || rx_valid === 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_no_strobe: got %0d strobes want 0", bad);
    end
    checks++;
    if (rx_data !== 8'hFF) begin
      errors++;
      $display("FAIL abort_rx_held: got %h want ff", rx_data);
    end
    $display("word abort: sent 5a aborted, rx_data %h", rx_data);
    run_word(8'hC3, 8'hC3, "after_abort");
  endtask

  task automatic test_back_to_back();
    int acc[2] = '{0, 0};
    int nacc = 0;
    int nrx = 0;
    logic done_at_acc2 = 1'b0;
    logic [7:0] rxs[2] = '{8'h00, 8'h00};
    int exp_gap;
    logic exp_done2;
`ifdef SHIFT_SEQ_BACK_TO_BACK_EN
    exp_gap = 34;
    exp_done2 = 1'b1;
`else
    exp_gap = 35;
    exp_done2 = 1'b0;
`endif
    loop_mode = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h11;
    for (int n = 0; n < 90; n++) begin
      if (s_valid === 1'b1 && s_ready === 1'b1 && nacc < 2) begin
        acc[nacc] = n;
        if (nacc == 1) done_at_acc2 = done;
        nacc++;
      end
      tick();
      if (nacc == 1) s_data = 8'h22;
      if (nacc == 2) s_valid = 1'b0;
      if (rx_valid === 1'b1 && nrx < 2) begin
        rxs[nrx] = rx_data;
        nrx++;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (nacc != 2 || acc[1] - acc[0] != exp_gap) begin
      errors++;
      $display("FAIL b2b_accept_gap: got %0d accepts gap %0d want 2 gap %0d",
               nacc, acc[1] - acc[0], exp_gap);
    end
    checks++;
    if (done_at_acc2 !== exp_done2) begin
      errors++;
      $display("FAIL b2b_accept_in_done: got %b want %b", done_at_acc2, exp_done2);
    end
    checks++;
    if (nrx != 2 || rxs[0] !== 8'h11 || rxs[1] !== 8'h22) begin
      errors++;
      $display("FAIL b2b_rx_data: got %0d words %h %h want 2 words 11 22", nrx, rxs[0], rxs[1]);
    end
    $display("words b2b: 11,22 accept gap %0d rx %h %h", acc[1] - acc[0], rxs[0], rxs[1]);
  endtask

  initial begin
    test_reset();
    loop_mode = 1'b1;
    run_word(8'hA5, 8'hA5, "loopback");
    test_reset_mid();
    loop_mode = 1'b0;
    run_word(8'h00, 8'hFF, "fill_ones");
    loop_mode = 1'b1;
    test_div1();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
